// File: rtl/mio_bus.sv
// mio_bus: bridges the control unit's held memory request onto a word RAM
// or a peripheral port, with per-region wait states and a ready pulse.
module mio_bus #(
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mio,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic        bus_err,
  output logic [1:0]  state_out,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [3:0]  io_addr,
  output logic        io_we,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
  localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

  state_t      state;
  state_t      state_nx;
  logic        req;
  logic        is_ram;
  logic        is_io;
  logic        bad;
  logic [9:0]  word_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        io_q;
  logic [3:0]  cnt;

  assign req    = cpu_mio & (mem_r | mem_w);
  assign is_ram = (addr[31:28] == 4'h0);
  assign is_io  = (addr[31:28] == 4'hE);
  assign bad    = ~(is_ram | is_io)
                | (addr[1:0] != 2'b00)
                | (mem_r & mem_w);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nx = bad ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Error flag and zeroed read data are set on entry so both are
  // already visible during the ERR ready cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      rdata   <= 32'h0;
      bus_err <= 1'b0;
      word_q  <= 10'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      cnt     <= 4'h0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            word_q  <= addr[11:2];
            wdata_q <= wdata;
            we_q    <= mem_w;
            io_q    <= is_io;
            cnt     <= is_io ? IO_CNT : RAM_CNT;
            if (bad) begin
              bus_err <= 1'b1;
              if (mem_r) begin
                rdata <= 32'h0;
              end
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            rdata <= io_q ? io_rdata : ram_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state_out = state;
  assign mio_ready = (state == S_DONE) | (state == S_ERR);
  assign ram_we    = (state == S_DONE) & we_q & ~io_q;
  assign io_we     = (state == S_DONE) & we_q & io_q;
  assign ram_addr  = word_q;
  assign ram_din   = wdata_q;
  assign io_addr   = word_q[3:0];
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: directed checks of mio_bus against a RAM model and a
// constant peripheral read value.
module tb_mio_bus;

  logic        clk;
  logic        reset;
  logic        cpu_mio;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;
  logic        bus_err;
  logic [1:0]  state_out;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [3:0]  io_addr;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  logic [31:0] mem [0:1023];
  int checks;
  int errs;

  mio_bus #(
    .RAM_WAIT(2),
    .IO_WAIT (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_mio  (cpu_mio),
    .mem_r    (mem_r),
    .mem_w    (mem_w),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .mio_ready(mio_ready),
    .bus_err  (bus_err),
    .state_out(state_out),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .io_addr  (io_addr),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int rdy_n,
                        output int rwe_n, output int iwe_n,
                        output logic [31:0] ra_at,
                        output logic [31:0] din_at,
                        output logic [31:0] ia_at,
                        output logic we_at);
    lat = 0; rdy_n = 0; rwe_n = 0; iwe_n = 0;
    ra_at = '1; din_at = '1; ia_at = '1; we_at = 1'b0;
    @(negedge clk);
    cpu_mio = 1'b1; mem_r = r; mem_w = w; addr = a; wdata = d;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      if (n == 1) begin
        #1;
        cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        addr = 32'hFFFF_FFFC; wdata = 32'h0;
      end
      @(negedge clk);
      if (ram_we) rwe_n++;
      if (io_we) iwe_n++;
      if (mio_ready) begin
        rdy_n++;
        if (lat == 0) begin
          lat    = n;
          ra_at  = 32'(ram_addr);
          din_at = ram_din;
          ia_at  = 32'(io_addr);
          we_at  = ram_we | io_we;
        end
      end
    end
  endtask

  int lat, rdy_n, rwe_n, iwe_n;
  logic [31:0] ra, din, ia;
  logic we_at;
  int first, second, tot, st_gap;

  initial begin
    checks = 0; errs = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1234_5678;
    mem[12] = 32'h0BAD_F00D;
    io_rdata = 32'h0;
    reset = 1'b0; cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(mio_ready), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b1;

    access(1'b1, 1'b0, 32'h0000_0010, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("rr_lat", 32'(lat), 32'd4);
    chk("rr_pulses", 32'(rdy_n), 32'd1);
    chk("rr_addr", ra, 32'd4);
    chk("rr_rdata", rdata, 32'h1234_5678);
    chk("rr_nowe", 32'(rwe_n), 32'd0);

    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("rw_lat", 32'(lat), 32'd4);
    chk("rw_we_n", 32'(rwe_n), 32'd1);
    chk("rw_we_rdy", 32'(we_at), 32'd1);
    chk("rw_addr", ra, 32'd8);
    chk("rw_din", din, 32'hCAFE_0001);
    chk("rw_mem", mem[8], 32'hCAFE_0001);
    chk("rw_rdata", rdata, 32'h1234_5678);

    io_rdata = 32'h0000_00A5;
    access(1'b1, 1'b0, 32'hE000_0004, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("ior_lat", 32'(lat), 32'd2);
    chk("ior_addr", ia, 32'd1);
    chk("ior_rdata", rdata, 32'h0000_00A5);

    access(1'b0, 1'b1, 32'hE000_0004, 32'h0000_0055,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("iow_lat", 32'(lat), 32'd2);
    chk("iow_we_n", 32'(iwe_n), 32'd1);
    chk("iow_ramwe", 32'(rwe_n), 32'd0);
    chk("iow_rdata", rdata, 32'h0000_00A5);

    access(1'b1, 1'b0, 32'h4000_0000, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("eu_lat", 32'(lat), 32'd1);
    chk("eu_pulses", 32'(rdy_n), 32'd1);
    chk("eu_strobes", 32'(rwe_n + iwe_n), 32'd0);
    chk("eu_rdata", rdata, 32'h0);
    chk("eu_err", 32'(bus_err), 32'd1);

    access(1'b1, 1'b0, 32'h0000_0010, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("g1_rdata", rdata, 32'h1234_5678);
    chk("g1_err", 32'(bus_err), 32'd1);

    access(1'b1, 1'b0, 32'h0000_0002, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("em_lat", 32'(lat), 32'd1);
    chk("em_rdata", rdata, 32'h0);
    chk("em_err", 32'(bus_err), 32'd1);

    access(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_0000,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("eb_lat", 32'(lat), 32'd1);
    chk("eb_strobes", 32'(rwe_n + iwe_n), 32'd0);
    chk("eb_mem", mem[4], 32'h1234_5678);
    chk("eb_err", 32'(bus_err), 32'd1);

    access(1'b1, 1'b0, 32'h0000_0030, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("dc_lat", 32'(lat), 32'd4);
    chk("dc_addr", ra, 32'd12);
    chk("dc_rdata", rdata, 32'h0BAD_F00D);
    chk("dc_err", 32'(bus_err), 32'd1);

    first = 0; second = 0; tot = 0; st_gap = -1;
    @(negedge clk);
    cpu_mio = 1'b1; mem_r = 1'b1; addr = 32'h0000_0010;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (first != 0 && n == first + 1) st_gap = int'(state_out);
      if (mio_ready) begin
        tot++;
        if (first == 0) begin
          first = n;
        end else if (second == 0) begin
          second = n;
          cpu_mio = 1'b0; mem_r = 1'b0;
        end
      end
    end
    chk("b2b_first", 32'(first), 32'd4);
    chk("b2b_gap", 32'(second - first), 32'd5);
    chk("b2b_idle", 32'(st_gap), 32'd0);
    chk("b2b_total", 32'(tot), 32'd2);

    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b1;
    addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    cpu_mio = 1'b0; mem_w = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ra_inwait", 32'(state_out), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ra_state", 32'(state_out), 32'd0);
    chk("ra_ready", 32'(mio_ready), 32'd0);
    chk("ra_we", 32'(ram_we | io_we), 32'd0);
    chk("ra_rdata", rdata, 32'h0);
    chk("ra_err", 32'(bus_err), 32'd0);
    chk("ra_raddr", 32'(ram_addr), 32'd0);
    chk("ra_din", ram_din, 32'h0);
    chk("ra_ioaddr", 32'(io_addr), 32'd0);
    chk("ra_iowd", io_wdata, 32'h0);
    reset = 1'b1;
    tot = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mio_ready | ram_we) tot++;
    end
    chk("ra_quiet", 32'(tot), 32'd0);
    chk("ra_mem", mem[8], 32'hCAFE_0001);

    access(1'b1, 1'b0, 32'h0000_0010, 32'h0,
           lat, rdy_n, rwe_n, iwe_n, ra, din, ia, we_at);
    chk("pr_lat", 32'(lat), 32'd4);
    chk("pr_rdata", rdata, 32'h1234_5678);
    chk("pr_err", 32'(bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
